// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control-bundle registers for the MIPS core.
// Exposes per-stage control bits, squashes on taken branches, inserts a bubble
// on load-use hazards, freezes on external stalls and counts inserted bubbles.
// Optional feature macro: CTRL_PIPE_HAZARD_EN (load-use detection; off by default).
module ctrl_pipe #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       EX,
   input  logic [2:0]       M,
   input  logic [1:0]       WB,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic [REG_W-1:0] rt_ex_in,
   input  logic             stall_in,
   input  logic             zero_mem,
   output logic             RegDst_ex,
   output logic             ALUOp_ex,
   output logic             ALUSrc_ex,
   output logic             Branch_mem,
   output logic             MemRead_mem,
   output logic             MemWrite_mem,
   output logic             RegWrite_wb,
   output logic             MemtoReg_wb,
   output logic             branch_taken,
   output logic             pc_hold,
   output logic [CNT_W-1:0] bubble_cnt
);

   // ID/EX contents
   logic [2:0]       ex_ex;
   logic [2:0]       m_ex;
   logic [1:0]       wb_ex;
   logic [REG_W-1:0] rt_ex;
   // EX/MEM contents
   logic [2:0]       m_mem;
   logic [1:0]       wb_mem;
   // MEM/WB contents
   logic [1:0]       wb_wb;

   logic             hazard;
   logic             cnt_full;

`ifdef CTRL_PIPE_HAZARD_EN
   // Load in EX whose destination matches a source of the instruction in ID.
   always_comb begin
      hazard = m_ex[1] & (rt_ex != '0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
   end
`else
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^{rs_id, rt_id, rt_ex};

   // Load-use detection disabled: bubbles come only from branch flushes.
   always_comb begin
      hazard = 1'b0;
   end
`endif

   // Branch resolution in MEM and PC/IF-ID hold request.
   always_comb begin
      branch_taken = m_mem[2] & zero_mem;
      pc_hold      = stall_in | (hazard & ~branch_taken);
      cnt_full     = (bubble_cnt == '1);
   end

   // Stage registers and bubble counter: reset > stall > flush > hazard > advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ex      <= '0;
         m_ex       <= '0;
         wb_ex      <= '0;
         rt_ex      <= '0;
         m_mem      <= '0;
         wb_mem     <= '0;
         wb_wb      <= '0;
         bubble_cnt <= '0;
      end else if (stall_in) begin
         ex_ex      <= ex_ex;
         m_ex       <= m_ex;
         wb_ex      <= wb_ex;
         rt_ex      <= rt_ex;
         m_mem      <= m_mem;
         wb_mem     <= wb_mem;
         wb_wb      <= wb_wb;
         bubble_cnt <= bubble_cnt;
      end else if (branch_taken) begin
         ex_ex  <= '0;
         m_ex   <= '0;
         wb_ex  <= '0;
         rt_ex  <= '0;
         m_mem  <= '0;
         wb_mem <= '0;
         wb_wb  <= wb_mem;
         if (!cnt_full)
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (hazard) begin
         ex_ex  <= '0;
         m_ex   <= '0;
         wb_ex  <= '0;
         rt_ex  <= '0;
         m_mem  <= m_ex;
         wb_mem <= wb_ex;
         wb_wb  <= wb_mem;
         if (!cnt_full)
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         ex_ex  <= EX;
         m_ex   <= M;
         wb_ex  <= WB;
         rt_ex  <= rt_ex_in;
         m_mem  <= m_ex;
         wb_mem <= wb_ex;
         wb_wb  <= wb_mem;
      end
   end

   // Per-stage control bit fan-out.
   always_comb begin
      RegDst_ex    = ex_ex[2];
      ALUOp_ex     = ex_ex[1];
      ALUSrc_ex    = ex_ex[0];
      Branch_mem   = m_mem[2];
      MemRead_mem  = m_mem[1];
      MemWrite_mem = m_mem[0];
      RegWrite_wb  = wb_wb[1];
      MemtoReg_wb  = wb_wb[0];
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_HAZARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [2:0]  EX;
   logic [2:0]  M;
   logic [1:0]  WB;
   logic [4:0]  rs_id;
   logic [4:0]  rt_id;
   logic [4:0]  rt_ex_in;
   logic        stall_in;
   logic        zero_mem;

   logic        RegDst_ex, ALUOp_ex, ALUSrc_ex;
   logic        Branch_mem, MemRead_mem, MemWrite_mem;
   logic        RegWrite_wb, MemtoReg_wb;
   logic        branch_taken, pc_hold;
   logic [15:0] bubble_cnt;

   logic        RegDst_ex2, ALUOp_ex2, ALUSrc_ex2;
   logic        Branch_mem2, MemRead_mem2, MemWrite_mem2;
   logic        RegWrite_wb2, MemtoReg_wb2;
   logic        branch_taken2, pc_hold2;
   logic [1:0]  bubble_cnt2;

   int n_chk;
   int n_fail;
   int exp_cnt;

   ctrl_pipe #(.REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .EX(EX), .M(M), .WB(WB),
      .rs_id(rs_id), .rt_id(rt_id), .rt_ex_in(rt_ex_in),
      .stall_in(stall_in), .zero_mem(zero_mem),
      .RegDst_ex(RegDst_ex), .ALUOp_ex(ALUOp_ex), .ALUSrc_ex(ALUSrc_ex),
      .Branch_mem(Branch_mem), .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
      .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
      .branch_taken(branch_taken), .pc_hold(pc_hold), .bubble_cnt(bubble_cnt)
   );

   ctrl_pipe #(.REG_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .EX(EX), .M(M), .WB(WB),
      .rs_id(rs_id), .rt_id(rt_id), .rt_ex_in(rt_ex_in),
      .stall_in(stall_in), .zero_mem(zero_mem),
      .RegDst_ex(RegDst_ex2), .ALUOp_ex(ALUOp_ex2), .ALUSrc_ex(ALUSrc_ex2),
      .Branch_mem(Branch_mem2), .MemRead_mem(MemRead_mem2), .MemWrite_mem(MemWrite_mem2),
      .RegWrite_wb(RegWrite_wb2), .MemtoReg_wb(MemtoReg_wb2),
      .branch_taken(branch_taken2), .pc_hold(pc_hold2), .bubble_cnt(bubble_cnt2)
   );

   logic [2:0] ex_o, mem_o;
   logic [1:0] wb_o;
   assign ex_o  = {RegDst_ex, ALUOp_ex, ALUSrc_ex};
   assign mem_o = {Branch_mem, MemRead_mem, MemWrite_mem};
   assign wb_o  = {RegWrite_wb, MemtoReg_wb};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [2:0] e, input logic [2:0] m, input logic [1:0] w,
                      input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rti);
      EX = e; M = m; WB = w; rt_ex_in = rt; rs_id = rs; rt_id = rti;
   endtask

   task automatic drain();
      drv(3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
      repeat (3) tick();
   endtask

   initial begin
      n_chk = 0; n_fail = 0; exp_cnt = 0;
      stall_in = 1'b0; zero_mem = 1'b1; rst = 1'b1;
      drv(3'b111, 3'b111, 2'b11, 5'd5, 5'd5, 5'd5);

      // Reset with nonzero inputs
      tick(); tick();
      check("rst_ex", ex_o, 0);
      check("rst_mem", mem_o, 0);
      check("rst_wb", wb_o, 0);
      check("rst_cnt", bubble_cnt, 0);
      check("rst_bt", branch_taken, 0);
      check("rst_hold", pc_hold, 0);
      rst = 1'b0; zero_mem = 1'b0;
      drv(3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
      tick();

      // lw pass-through followed by independent R-type
      drv(3'b001, 3'b010, 2'b11, 5'd3, 5'd0, 5'd0);
      #1 check("lw_hold0", pc_hold, 0);
      tick();
      check("lw_ex1", ex_o, 3'b001);
      drv(3'b110, 3'b000, 2'b10, 5'd4, 5'd1, 5'd2);
      #1 check("lw_hold1", pc_hold, 0);
      tick();
      check("lw_mem2", mem_o, 3'b010);
      check("r_ex2", ex_o, 3'b110);
      drv(3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
      #1 check("lw_hold2", pc_hold, 0);
      tick();
      check("lw_wb3", wb_o, 2'b11);
      check("r_mem3", mem_o, 3'b000);
      tick();
      check("r_wb4", wb_o, 2'b10);
      drain();

      // Load-use: lw rt=5, then rs_id=5
      drv(3'b001, 3'b010, 2'b11, 5'd5, 5'd0, 5'd0);
      tick();
      drv(3'b110, 3'b000, 2'b10, 5'd6, 5'd5, 5'd7);
      #1 check("lu_hold", pc_hold, HZ);
      tick();
      exp_cnt += HZ ? 1 : 0;
      check("lu_ex_bub", ex_o, HZ ? 3'b000 : 3'b110);
      check("lu_mem", mem_o, 3'b010);
      check("lu_cnt", bubble_cnt, exp_cnt);
      #1 check("lu_hold_rel", pc_hold, 0);
      tick();
      check("lu_ex_dep", ex_o, 3'b110);
      check("lu_wb", wb_o, 2'b11);
      check("lu_cnt2", bubble_cnt, exp_cnt);
      drain();

      // Load with rt=0 never stalls
      drv(3'b001, 3'b010, 2'b11, 5'd0, 5'd0, 5'd0);
      tick();
      drv(3'b110, 3'b000, 2'b10, 5'd6, 5'd0, 5'd0);
      #1 check("lu0_hold", pc_hold, 0);
      tick();
      check("lu0_ex", ex_o, 3'b110);
      check("lu0_cnt", bubble_cnt, exp_cnt);
      drain();

      // Branch flush
      drv(3'b010, 3'b100, 2'b00, 5'd0, 5'd0, 5'd0);
      tick();
      drv(3'b110, 3'b000, 2'b10, 5'd8, 5'd1, 5'd0);
      tick();
      drv(3'b001, 3'b010, 2'b11, 5'd9, 5'd2, 5'd3);
      zero_mem = 1'b1;
      #1 check("br_taken", branch_taken, 1);
      check("br_hold", pc_hold, 0);
      tick();
      exp_cnt += 1;
      zero_mem = 1'b0;
      check("br_ex", ex_o, 0);
      check("br_mem", mem_o, 0);
      check("br_wb", wb_o, 2'b00);
      check("br_cnt", bubble_cnt, exp_cnt);
      drain();

      // Flush and load-use in the same cycle
      drv(3'b010, 3'b100, 2'b00, 5'd0, 5'd0, 5'd0);
      tick();
      drv(3'b001, 3'b010, 2'b11, 5'd5, 5'd0, 5'd0);
      tick();
      drv(3'b110, 3'b000, 2'b10, 5'd6, 5'd5, 5'd0);
      zero_mem = 1'b1;
      #1 check("bh_taken", branch_taken, 1);
      check("bh_hold", pc_hold, 0);
      tick();
      exp_cnt += 1;
      zero_mem = 1'b0;
      check("bh_ex", ex_o, 0);
      check("bh_mem", mem_o, 0);
      check("bh_cnt", bubble_cnt, exp_cnt);
      #1 check("bh_hold2", pc_hold, 0);
      drain();

      // Freeze mid-stream: A=R, B=lw, C=sw then stall with D waiting
      drv(3'b110, 3'b000, 2'b10, 5'd2, 5'd0, 5'd0);
      tick();
      drv(3'b001, 3'b010, 2'b11, 5'd3, 5'd0, 5'd0);
      tick();
      drv(3'b011, 3'b001, 2'b00, 5'd4, 5'd1, 5'd4);
      tick();
      drv(3'b100, 3'b000, 2'b10, 5'd2, 5'd9, 5'd9);
      stall_in = 1'b1; zero_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("frz_hold", pc_hold, 1);
         tick();
         check("frz_ex", ex_o, 3'b011);
         check("frz_mem", mem_o, 3'b010);
         check("frz_wb", wb_o, 2'b10);
         check("frz_cnt", bubble_cnt, exp_cnt);
      end
      stall_in = 1'b0; zero_mem = 1'b0;
      #1 check("frz_rel", pc_hold, 0);
      tick();
      check("res_ex", ex_o, 3'b100);
      check("res_mem", mem_o, 3'b001);
      check("res_wb", wb_o, 2'b11);
      drv(3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
      tick();
      check("res_mem2", mem_o, 3'b000);
      check("res_wb2", wb_o, 2'b00);
      drain();

      // Saturation: 5 load-use hazards into both counters
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("sat_rst", bubble_cnt2, 0);
      for (int i = 0; i < 5; i++) begin
         drv(3'b001, 3'b010, 2'b11, 5'd5, 5'd0, 5'd0);
         tick();
         drv(3'b110, 3'b000, 2'b10, 5'd6, 5'd5, 5'd0);
         #1 check("sat_hold", pc_hold, HZ);
         tick();
         tick();
         check("sat_cnt16", bubble_cnt, HZ ? i + 1 : 0);
         check("sat_cnt2", bubble_cnt2, HZ ? ((i + 1 > 3) ? 3 : i + 1) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
